// File: rtl/counter_pkg.sv
// Shared types and constants for the BCD counter / seven-segment display block.
package counter_pkg;

  // Number of BCD digits in the count and anodes on the display.
  localparam int NUM_DIGITS = 4;

  // One BCD digit.
  typedef logic [3:0] digit_t;

  // Active-low cathode pattern with every segment off. Bit order is g..a.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low glyphs for digits 0..9. Bit order is g..a.
  // Element 9 is written first because the concatenation fills from the MSB.
  localparam logic [9:0][6:0] SEG_GLYPHS = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/bcd_counter_display_if.sv
// Control inputs and display/count outputs of the BCD counter block.
interface bcd_counter_display_if;

  logic        slow_clk;
  logic        en;
  logic        up;
  logic        clr;
  logic [15:0] count;
  logic        carry;
  logic [3:0]  an;
  logic [6:0]  seg;

  // Driver side: supplies the slow wave and controls, observes the results.
  modport master (
    output slow_clk, en, up, clr,
    input  count, carry, an, seg
  );

  // Counter side: consumes the slow wave and controls, drives the results.
  modport slave (
    input  slow_clk, en, up, clr,
    output count, carry, an, seg
  );

endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes blank.
module seg7_decode
  import counter_pkg::*;
(
  input  digit_t      digit,
  output logic [6:0]  seg
);

  // Map each legal digit onto its glyph and everything else onto blank.
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_GLYPHS[0];
      4'd1:    seg = SEG_GLYPHS[1];
      4'd2:    seg = SEG_GLYPHS[2];
      4'd3:    seg = SEG_GLYPHS[3];
      4'd4:    seg = SEG_GLYPHS[4];
      4'd5:    seg = SEG_GLYPHS[5];
      4'd6:    seg = SEG_GLYPHS[6];
      4'd7:    seg = SEG_GLYPHS[7];
      4'd8:    seg = SEG_GLYPHS[8];
      4'd9:    seg = SEG_GLYPHS[9];
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_counter_display.sv
// Four-digit BCD up/down counter stepped by rising edges of a slow square wave,
// with a time-multiplexed common-anode seven-segment display driver.
// The slow wave is only ever treated as data in the clk domain.
module bcd_counter_display
  import counter_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int SCAN_W   = 16
)
(
  input  logic                    clk,
  input  logic                    rst,
  bcd_counter_display_if.slave    bus
);

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  // Edge detect: slow_r is the clk-domain sample of the wave, slow_q_r the
  // previous sample. The extra input register gives the two-edge latency
  // from the wave first being sampled high to the count moving.
  logic slow_r;
  logic slow_q_r;
  logic step_s;

  // Counter state and next-value candidates.
  logic [15:0] count_r;
  logic        carry_r;
  logic [15:0] count_inc_s;
  logic [15:0] count_dec_s;
  logic        inc_ripple_s;
  logic        dec_ripple_s;

  // Display scan state.
  logic [SCAN_W-1:0] scan_cnt_r;
  logic [1:0]        digit_idx_r;
  digit_t            sel_digit_s;
  logic [3:0]        an_next_s;
  logic [6:0]        seg_dec_s;
  logic [3:0]        an_r;
  logic [6:0]        seg_r;

  assign step_s = slow_r & ~slow_q_r;

  // Register the slow wave and keep the previous sample for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      slow_r   <= 1'b0;
      slow_q_r <= 1'b0;
    end else begin
      slow_r   <= bus.slow_clk;
      slow_q_r <= slow_r;
    end
  end

  // BCD increment: 9 rolls to 0 and ripples a carry into the next digit.
  always_comb begin
    count_inc_s  = count_r;
    inc_ripple_s = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (inc_ripple_s) begin
        if (count_r[i*4 +: 4] == 4'd9) begin
          count_inc_s[i*4 +: 4] = 4'd0;
        end else begin
          count_inc_s[i*4 +: 4] = count_r[i*4 +: 4] + 4'd1;
          inc_ripple_s          = 1'b0;
        end
      end else begin
        count_inc_s[i*4 +: 4] = count_r[i*4 +: 4];
      end
    end
  end

  // BCD decrement: 0 rolls to 9 and ripples a borrow into the next digit.
  always_comb begin
    count_dec_s  = count_r;
    dec_ripple_s = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dec_ripple_s) begin
        if (count_r[i*4 +: 4] == 4'd0) begin
          count_dec_s[i*4 +: 4] = 4'd9;
        end else begin
          count_dec_s[i*4 +: 4] = count_r[i*4 +: 4] - 4'd1;
          dec_ripple_s          = 1'b0;
        end
      end else begin
        count_dec_s[i*4 +: 4] = count_r[i*4 +: 4];
      end
    end
  end

  // Count register with clear over enabled steps; a ripple out of the top
  // digit is the wrap and raises carry for exactly that one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 16'h0000;
      carry_r <= 1'b0;
    end else if (bus.clr) begin
      count_r <= 16'h0000;
      carry_r <= 1'b0;
    end else if (step_s && bus.en) begin
      if (bus.up) begin
        count_r <= count_inc_s;
        carry_r <= inc_ripple_s;
      end else begin
        count_r <= count_dec_s;
        carry_r <= dec_ripple_s;
      end
    end else begin
      count_r <= count_r;
      carry_r <= 1'b0;
    end
  end

  // Scan prescaler; the digit index advances each time the prescaler wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_r  <= {SCAN_W{1'b0}};
      digit_idx_r <= 2'd0;
    end else if (scan_cnt_r == SCAN_LAST) begin
      scan_cnt_r  <= {SCAN_W{1'b0}};
      digit_idx_r <= digit_idx_r + 2'd1;
    end else begin
      scan_cnt_r  <= scan_cnt_r + {{(SCAN_W-1){1'b0}}, 1'b1};
      digit_idx_r <= digit_idx_r;
    end
  end

  // Pick the count digit and the active-low anode for the current index.
  always_comb begin
    sel_digit_s = count_r[3:0];
    an_next_s   = 4'b1110;
    case (digit_idx_r)
      2'd0: begin
        sel_digit_s = count_r[3:0];
        an_next_s   = 4'b1110;
      end
      2'd1: begin
        sel_digit_s = count_r[7:4];
        an_next_s   = 4'b1101;
      end
      2'd2: begin
        sel_digit_s = count_r[11:8];
        an_next_s   = 4'b1011;
      end
      2'd3: begin
        sel_digit_s = count_r[15:12];
        an_next_s   = 4'b0111;
      end
      default: begin
        sel_digit_s = count_r[3:0];
        an_next_s   = 4'b1110;
      end
    endcase
  end

  seg7_decode u_seg7_decode (
    .digit (sel_digit_s),
    .seg   (seg_dec_s)
  );

  // Register anode and cathode drive so the pins never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_r  <= 4'b1110;
      seg_r <= SEG_GLYPHS[0];
    end else begin
      an_r  <= an_next_s;
      seg_r <= seg_dec_s;
    end
  end

  assign bus.count = count_r;
  assign bus.carry = carry_r;
  assign bus.an    = an_r;
  assign bus.seg   = seg_r;

endmodule

// File: tb/tb_bcd_counter_display.sv
// Self-checking bench for bcd_counter_display: directed vector table, hand
// sequences for counting/scan, and randomized stimulus against a model that
// tracks the count as a plain integer 0..9999.
module tb_bcd_counter_display;

  localparam int SCAN_DIV = 4;
  localparam int SCAN_W   = 3;

  logic clk = 1'b0;
  logic rst;

  bcd_counter_display_if bus();

  bcd_counter_display #(
    .SCAN_DIV (SCAN_DIV),
    .SCAN_W   (SCAN_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Independent glyph table, index = digit value, active-low g..a.
  logic [6:0] glyph [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000};
  int pow10 [4] = '{1, 10, 100, 1000};

  // Reference model state.
  int         m_count;
  logic       m_carry;
  logic       m_s1;      // wave as sampled at the previous edge
  logic       m_s2;      // wave as sampled two edges ago
  int         m_cycles;  // clk edges since reset release
  logic [3:0] m_an;
  logic [6:0] m_seg;

  typedef struct {
    logic        rst;
    logic        slow;
    logic        en;
    logic        up;
    logic        clr;
    logic [15:0] exp_count;
    logic        exp_carry;
  } vec_t;

  vec_t vecs [22];

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic e, input logic u, input logic c);
    rst          = r;
    bus.slow_clk = s;
    bus.en       = e;
    bus.up       = u;
    bus.clr      = c;
  endtask

  // Advance the model by one clk edge using the inputs that were stable at it.
  task automatic model_step();
    int  idx;
    logic stp;
    if (rst) begin
      m_count  = 0;
      m_carry  = 1'b0;
      m_s1     = 1'b0;
      m_s2     = 1'b0;
      m_cycles = 0;
      m_an     = 4'b1110;
      m_seg    = glyph[0];
    end else begin
      // A rising edge is acted on one edge after it is first sampled high.
      stp   = m_s1 && !m_s2;
      idx   = (m_cycles / SCAN_DIV) % 4;
      m_an  = ~(4'(1) << idx);
      m_seg = glyph[(m_count / pow10[idx]) % 10];
      m_cycles++;
      if (bus.clr) begin
        m_count = 0;
        m_carry = 1'b0;
      end else if (stp && bus.en) begin
        if (bus.up) begin
          m_carry = (m_count == 9999);
          m_count = (m_count + 1) % 10000;
        end else begin
          m_carry = (m_count == 0);
          m_count = (m_count + 9999) % 10000;
        end
      end else begin
        m_carry = 1'b0;
      end
      m_s2 = m_s1;
      m_s1 = bus.slow_clk;
    end
  endtask

  // One clk cycle: edge, model update, then sample the DUT 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model_count", bus.count, to_bcd(m_count));
    chk("model_carry", bus.carry, m_carry);
    chk("model_an", bus.an, m_an);
    chk("model_seg", bus.seg, m_seg);
  endtask

  initial begin
    logic [3:0] an_pat  [4];
    logic [6:0] seg_pat [4];
    int n;

    an_pat  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_pat = '{7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};

    //               rst   slow  en    up    clr   count     carry
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0002, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0002, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h9999, 1'b1};
    vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h9999, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h9999, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h9999, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1};
    vecs[21] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};

    // Reset held for three cycles, then released.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("rst_count", bus.count, 16'h0000);
    chk("rst_carry", bus.carry, 1'b0);
    chk("rst_an", bus.an, 4'b1110);
    chk("rst_seg", bus.seg, 7'b1000000);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("rel_count", bus.count, 16'h0000);
    chk("rel_an", bus.an, 4'b1110);
    chk("rel_seg", bus.seg, 7'b1000000);

    // Directed vector table: latency, falling edges, en=0, clr, both wraps.
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].rst, vecs[i].slow, vecs[i].en, vecs[i].up, vecs[i].clr);
      tick();
      chk($sformatf("vec%0d_count", i), bus.count, vecs[i].exp_count);
      chk($sformatf("vec%0d_carry", i), bus.carry, vecs[i].exp_carry);
    end

    // Twelve up edges from reset; each moves the count once, on its second edge.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 12; k++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      chk("up_hold", bus.count, to_bcd(k));
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      chk("up_step", bus.count, to_bcd(k + 1));
    end
    chk("up12", bus.count, 16'h0012);

    // Keep counting up to 4321, then watch the display scan.
    for (int k = 12; k < 4321; k++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
    end
    chk("at4321", bus.count, 16'h4321);
    n = 0;
    while (bus.an !== 4'b0111 && n < 20) begin
      tick();
      n++;
    end
    chk("scan_find_0111", bus.an, 4'b0111);
    n = 0;
    while (bus.an !== 4'b1110 && n < 8) begin
      tick();
      n++;
    end
    chk("scan_find_1110", bus.an, 4'b1110);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      chk($sformatf("scan_an%0d", k), bus.an, an_pat[k / 4]);
      chk($sformatf("scan_seg%0d", k), bus.seg, seg_pat[k / 4]);
    end

    // Randomized stimulus with occasional reset and clear, checked by the model.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(0, 299) == 0),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) != 0),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 99) == 0));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_counter_display.md
Name: bcd_counter_display

Overview:
- Downstream consumer of the clock divider's slow square wave (`newclk`).
- Detects each rising edge of that wave in the `clk` domain and steps a 4-digit BCD up/down counter (0000–9999).
- Time-multiplexes the count onto a 4-digit common-anode seven-segment display.
- Fully synchronous to `clk`; the slow wave is used only as data, never as a clock.

Parameters:
- SCAN_DIV, 50000, `clk` cycles each digit stays lit before the scan advances (must be ≥2).
- SCAN_W, 16, width of the scan prescaler; must satisfy 2^SCAN_W ≥ SCAN_DIV.

Ports:
- clk  in  1  system clock, same clock that drives the divider.
- rst  in  1  synchronous, active-high reset.
- slow_clk  in  1  divider output square wave, registered in `clk` domain.
- en  in  1  count enable; steps are ignored when low.
- up  in  1  direction: 1 = increment, 0 = decrement.
- clr  in  1  synchronous clear of the count.
- count  out  16  BCD value; digit3 in [15:12] … digit0 in [3:0].
- carry  out  1  one-cycle pulse on wrap (9999→0000 up, 0000→9999 down).
- an  out  4  digit anodes, active-low one-hot; an[0] = digit0.
- seg  out  7  cathodes, active-low; seg[0]=a … seg[6]=g.

Behaviour:
- Reset (rst=1 at a clk edge):
  - count=16'h0000, carry=0, slow_q=0.
  - Scan prescaler=0, digit index=0.
  - an=4'b1110, seg=7'b1000000 (glyph "0").
- Edge detect:
  - slow_q <= slow_clk every cycle.
  - step = slow_clk & ~slow_q, one clk cycle wide per rising edge of slow_clk.
  - Falling edges are ignored.
- Count update at the clk edge, priority rst > clr > (step & en):
  - clr=1: count <= 0 and carry <= 0, regardless of step.
  - step & en & up: BCD increment.
    - A digit at 9 becomes 0 and carries into the next digit.
    - 9999 → 0000 with carry <= 1.
  - step & en & ~up: BCD decrement.
    - A digit at 0 becomes 9 and borrows from the next digit.
    - 0000 → 9999 with carry <= 1.
  - All other cycles: count holds and carry <= 0, so carry is exactly one cycle wide.
- Latency: count reflects a slow_clk rising edge one clk edge after the step cycle, i.e. two clk edges after slow_clk is first sampled high.
- Counting with en=0: an edge with en=0 is lost; there is no pending or queued step.
- Direction change: up may change on any cycle; it is sampled only in step cycles.
- Illegal digits: a digit value of A–F cannot arise from reset or counting.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - On wrap, the digit index increments modulo 4.
  - an and seg are registered, one clk behind the digit index and count.
  - seg decodes the selected count digit.
  - Decoding of digits 0–9 is standard; values A–F decode to blank (7'b1111111).
- Reset mid-operation: all state returns to reset values on the same edge; no partial update survives.

Decomposition:
- Package `counter_pkg` holds:
  - SEG_BLANK constant.
  - Ten-entry seven-segment glyph constants for digits 0–9.
  - NUM_DIGITS = 4.
  - The digit-nibble typedef.
- Sub-module `seg7_decode` (combinational): 4-bit BCD in, 7-bit active-low segments out.
- Counter, edge detect and scan logic stay in the top module.

Test Plan:
- Reset: with SCAN_DIV=4 for sim, assert rst 3 cycles, release → count=0000, carry=0, an=1110, seg=1000000.
- Up counting: en=1, up=1, 12 slow_clk rising edges → count=16'h0012; each edge advances count exactly once, two clk edges after slow_clk goes high.
- Up wrap: preload by stepping to 9999, one more edge → count=0000, carry high exactly 1 cycle; a falling edge → no change.
- Down wrap: from 0000 with up=0, one edge → count=9999 and carry pulse; next edge → 9998.
- clr and en=0:
  - en=0 with 3 edges → count unchanged.
  - clr=1 in the same cycle as a step → count=0000, carry=0.
- Scan: count=16'h4321, SCAN_DIV=4 → an cycles 1110,1101,1011,0111 every 4 clks.
  - seg shows 1,2,3,4 = 1111001, 0100100, 0110000, 0011001.
